// File: rtl/sram_pkg.sv
// Shared types and default sizing for the cleared synchronous SRAM model.
package sram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } sram_state_t;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam logic [7:0] CLEAR_VAL = 8'h00;

endpackage

// File: rtl/sram_clear_ctrl.sv
// Sequential clear engine: walks the array one word per clock after reset or on request.
module sram_clear_ctrl #(
    parameter int ADDR_W = sram_pkg::ADDR_W,
    parameter int DEPTH  = sram_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_W-1:0]     clr_addr,
    output logic                  clear_done,
    output sram_pkg::sram_state_t state_dbg
);
    import sram_pkg::*;

    // One extra counter bit keeps DEPTH == 2**ADDR_W from wrapping to zero early.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

    sram_state_t       r_state;
    logic [ADDR_W:0]   r_cnt;
    logic              r_busy;
    logic              r_done;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (clear) begin
                        r_state <= CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_done <= 1'b0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign clr_we     = (r_state == CLEAR);
    assign clr_addr   = r_cnt[ADDR_W-1:0];
    assign clear_done = r_done;
    assign state_dbg  = r_state;

endmodule

// File: rtl/sram_sync_clr.sv
// Single-port SRAM with registered read, per-access status and a built-in clear engine.
module sram_sync_clr #(
    parameter int                DATA_W    = sram_pkg::DATA_W,
    parameter int                ADDR_W    = sram_pkg::ADDR_W,
    parameter int                DEPTH     = sram_pkg::DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(sram_pkg::CLEAR_VAL)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              wen,
    input  logic              ren,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              clear_done,
    output logic              err
);
    import sram_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_err;

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    sram_state_t       w_state;
    logic              w_idle;
    logic              w_in_range;
    logic              w_wr;
    logic [DATA_W-1:0] w_rd_word;

    sram_clear_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_ctrl (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .busy       (busy),
        .clr_we     (w_clr_we),
        .clr_addr   (w_clr_addr),
        .clear_done (clear_done),
        .state_dbg  (w_state)
    );

    assign w_idle     = (w_state == IDLE);
    assign w_in_range = ({1'b0, addr} < DEPTH_EXT);
    assign w_wr       = w_idle & wen & w_in_range;
    assign w_rd_word  = w_in_range ? r_mem[addr] : '0;

    // The clear engine owns the write port whenever it runs; user writes only land in IDLE.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= CLEAR_VAL;
        end else if (w_wr) begin
            r_mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err    <= (wen | ren) & (~w_idle | ~w_in_range);
            r_rvalid <= w_idle & ren;
            if (w_idle && ren) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign err    = r_err;

endmodule
